// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N requesters share a single registered W-bit output channel.
// A round-robin grant selects one valid requester per cycle. Its data is
// captured into the output register whenever the output is empty or is being
// drained in the same cycle.
//
// Ports:
//   clk        - single clock, all state updates on posedge
//   rst        - synchronous active-low reset
//   in_valid   - [N]   per-requester valid
//   in_data    - [N*W] requester k data in bits [k*W +: W]
//   in_ready   - [N]   one-hot-or-zero accept strobe (combinational)
//   out_valid  - output register holds an item
//   out_data   - [W]   registered data of the granted requester
//   out_id     - [$clog2(N)] index of the requester that supplied out_data
//   out_ready  - downstream accepts when out_valid && out_ready
module rr_mux_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            in_valid,
    input  logic [N*W-1:0]          in_data,
    output logic [N-1:0]            in_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic [$clog2(N)-1:0]    out_id,
    input  logic                    out_ready
);

    localparam int unsigned IDW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    data_q, data_d;
    logic [IDW-1:0]  id_q, id_d;

    logic [2*N-1:0]  dbl_valid_c;
    logic [2*N-1:0]  rot_valid_c;
    logic [IDW:0]    grant_sum_c;
    logic [IDW-1:0]  grant_c;
    logic            found_c;
    logic            can_load_c;
    logic            accept_c;
    logic [W-1:0]    sel_data_c;

    // Round-robin search: rotate in_valid so ptr lands at bit 0, take the
    // lowest set bit, then map the offset back to a requester index mod N.
    always_comb begin
        dbl_valid_c = {in_valid, in_valid};
        rot_valid_c = dbl_valid_c >> ptr_q;
        found_c     = 1'b0;
        grant_sum_c = '0;
        grant_c     = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found_c && rot_valid_c[i]) begin
                found_c     = 1'b1;
                grant_sum_c = {1'b0, ptr_q} + (IDW+1)'(i);
            end
        end
        if (grant_sum_c >= (IDW+1)'(N)) begin
            grant_sum_c = grant_sum_c - (IDW+1)'(N);
        end
        grant_c = grant_sum_c[IDW-1:0];
    end

    // N:1 data select for the granted requester.
    always_comb begin
        sel_data_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (grant_c == IDW'(k)) begin
                sel_data_c = in_data[k*W +: W];
            end
        end
    end

    // Accept strobe; reset blocks any acceptance in that cycle.
    always_comb begin
        can_load_c = (state_q == IDLE) || out_ready;
        accept_c   = rst && can_load_c && found_c;
        in_ready   = '0;
        if (accept_c) begin
            in_ready = N'(1) << grant_c;
        end
    end

    // Next-state: load on acceptance, drop to IDLE when drained with nothing new.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (accept_c) begin
            state_d = BUSY;
            data_d  = sel_data_c;
            id_d    = grant_c;
            ptr_d   = (grant_c == IDW'(N-1)) ? '0 : grant_c + IDW'(1);
        end else if (state_q == BUSY && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = (state_q == BUSY);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter (N=4, W=8): directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_rr_mux_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned WB = 8;

    logic            clk;
    logic            rst;
    logic [NB-1:0]   in_valid;
    logic [NB*WB-1:0] in_data;
    logic [NB-1:0]   in_ready;
    logic            out_valid;
    logic [WB-1:0]   out_data;
    logic [1:0]      out_id;
    logic            out_ready;

    rr_mux_arbiter #(.N(NB), .W(WB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: is an item held, which requester is next in line,
    // and the item currently presented downstream.
    bit       m_busy = 0;
    int       m_ptr  = 0;
    int       m_data = 0;
    int       m_id   = 0;
    logic [NB-1:0] last_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check the combinational accept strobe,
    // clock, advance the model, check registered outputs.
    task automatic cyc(input logic [NB-1:0] v, input logic ordy, input logic r);
        int  g;
        bit  any;
        logic [NB-1:0] exp_rdy;
        in_valid  = v;
        out_ready = ordy;
        rst       = r;
        #2;
        g   = -1;
        any = 0;
        for (int j = 0; j < int'(NB); j++) begin
            int k;
            k = (m_ptr + j) % NB;
            if (!any && v[k]) begin
                g   = k;
                any = 1;
            end
        end
        exp_rdy = '0;
        if (r && any && (!m_busy || ordy)) exp_rdy[g] = 1'b1;
        last_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (!r) begin
            m_busy = 0; m_ptr = 0; m_data = 0; m_id = 0;
        end else if (exp_rdy != '0) begin
            m_busy = 1;
            m_data = int'(in_data[g*WB +: WB]);
            m_id   = g;
            m_ptr  = (g + 1) % NB;
        end else if (m_busy && ordy) begin
            m_busy = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_busy));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_id",    32'(out_id),    32'(m_id));
    endtask

    initial begin
        logic [NB-1:0] rr_order [5];
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b0;

        // Reset state
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("reset_out_data", 32'(out_data), 32'h0);

        // Single request from requester 2
        in_data[2*WB +: WB] = 8'hA5;
        cyc(4'b0100, 1'b1, 1'b1);
        chk("single_rdy",  32'(last_rdy), 32'h4);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_id",   32'(out_id),   32'h2);
        cyc(4'b0000, 1'b1, 1'b1);

        // Pointer at 3 wraps to requester 0, then requester 1
        cyc(4'b0011, 1'b1, 1'b1);
        chk("wrap_grant0", 32'(last_rdy), 32'h1);
        cyc(4'b0011, 1'b1, 1'b1);
        chk("wrap_grant1", 32'(last_rdy), 32'h2);

        // Round robin with all requesting from reset
        cyc(4'b0000, 1'b1, 1'b0);
        in_data = 32'h44332211;
        rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b1, 1'b1);
            chk("rr_grant", 32'(last_rdy), 32'(rr_order[i]));
            chk("rr_valid", 32'(out_valid), 32'h1);
        end

        // Backpressure: requester 1 item held for 3 cycles, then requester 3
        cyc(4'b0010, 1'b1, 1'b1);
        chk("bp_load_id", 32'(out_id), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1001, 1'b0, 1'b1);
            chk("bp_hold_rdy",  32'(last_rdy), 32'h0);
            chk("bp_hold_data", 32'(out_data), 32'h22);
            chk("bp_hold_id",   32'(out_id),   32'h1);
        end
        cyc(4'b1001, 1'b1, 1'b1);
        chk("bp_release_rdy", 32'(last_rdy), 32'h8);
        chk("bp_release_id",  32'(out_id),   32'h3);

        // Drain to idle keeps last data
        cyc(4'b0000, 1'b1, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_data",  32'(out_data),  32'h44);

        // Reset mid-transfer
        in_data[0 +: WB] = 8'h3C;
        cyc(4'b0001, 1'b1, 1'b1);
        chk("mid_load_data", 32'(out_data), 32'h3C);
        cyc(4'b0010, 1'b0, 1'b0);
        chk("mid_rst_rdy",   32'(last_rdy),  32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data",  32'(out_data),  32'h0);
        chk("mid_rst_id",    32'(out_id),    32'h0);
        cyc(4'b0110, 1'b1, 1'b1);
        chk("post_rst_grant", 32'(last_rdy), 32'h2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_data = $urandom;
            cyc(NB'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter W, default 8, data width per requester.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset: sampled on posedge clk, state reset while rst==0.
REQ-005 SHALL have port in_valid, input, N, per-requester request/valid.
REQ-006 SHALL have port in_data, input, N*W, requester k data in bits [k*W +: W].
REQ-007 SHALL have port in_ready, output, N, one-hot-or-zero accept strobe per requester.
REQ-008 SHALL have port out_valid, output, 1, shared output channel holds a valid item.
REQ-009 SHALL have port out_data, output, W, registered data of the granted requester.
REQ-010 SHALL have port out_id, output, $clog2(N), index of the requester that supplied out_data.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the item when out_valid && out_ready.

Function
REQ-012 SHALL share one W-bit output register among N requesters via an N:1 data select driven by a round-robin grant.
REQ-013 SHALL implement two states: IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 SHALL define can_load = (state==IDLE) || out_ready.
REQ-015 SHALL compute grant = first k with in_valid[k]==1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
REQ-016 SHALL drive in_ready[grant]=1 combinationally only when can_load && |in_valid; all other in_ready bits 0; in_ready all 0 when in_valid==0.
REQ-017 SHALL treat in_valid[k] && in_ready[k] as acceptance: next cycle out_data=in_data[k], out_id=k, out_valid=1.
REQ-018 SHALL have latency exactly 1 cycle from acceptance to out_valid.
REQ-019 SHALL update ptr to (grant+1) mod N on each acceptance; ptr wraps N-1 -> 0; ptr unchanged otherwise.
REQ-020 SHALL hold out_data, out_id, out_valid stable in BUSY while out_ready==0 (no new acceptance).
REQ-021 SHALL, in BUSY with out_ready==1 and any in_valid set, drain and reload in the same cycle (stay BUSY, throughput 1 item/cycle).
REQ-022 SHALL, in BUSY with out_ready==1 and in_valid==0, go IDLE; out_valid=0 next cycle; out_data/out_id keep last value.
REQ-023 SHALL, in IDLE with in_valid==0, remain IDLE; out_ready ignored in IDLE.
REQ-024 SHALL guarantee starvation freedom: a requester holding in_valid is accepted within N acceptances.
REQ-025 SHALL not depend on in_valid of non-granted requesters staying stable; requesters may drop in_valid without penalty.

Reset
REQ-026 SHALL, while rst==0 at posedge clk, set state=IDLE, ptr=0, out_valid=0, out_data=0, out_id=0.
REQ-027 SHALL force in_ready=0 during any cycle with rst==0.
REQ-028 SHALL discard a held BUSY item when reset is asserted mid-transfer; no acceptance occurs in that cycle and ptr returns to 0.

Verification
REQ-029 Single request: N=4, reset, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=8'hA5, out_id=2; ptr=3.
REQ-030 Round robin: in_valid=4'b1111 held, out_ready=1 from reset -> grant order 0,1,2,3,0 on consecutive cycles, out_id follows one cycle later, out_valid continuously 1.
REQ-031 Backpressure: item from requester 1 in BUSY, out_ready=0 for 3 cycles with in_valid=4'b1001 -> in_ready=0, out_data/out_id unchanged all 3 cycles; on out_ready=1 requester 3 accepted (ptr=2).
REQ-032 Wrap: ptr=3, in_valid=4'b0011 -> requester 0 granted, ptr=1; next grant requester 1.
REQ-033 Drain to idle: BUSY, out_ready=1, in_valid=0 -> next cycle out_valid=0, in_ready=0, out_data retains last value.
REQ-034 Reset mid-operation: BUSY with out_data=8'h3C, rst=0 for 1 cycle -> out_valid=0, out_data=0, out_id=0, in_ready=0; first post-reset grant searches from requester 0.
